// File: rtl/arbiter_4.sv
// Round-robin arbiter for four requesters with registered one-hot grants and
// encoded owner index. Define ARB_TIMEOUT_EN to add forced revocation after MAX_HOLD cycles.
module arbiter_4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic req4,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3,
  output logic gnt4,
  output logic valid,
  output logic num1,
  output logic num2
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, nxt_state;
  logic [1:0] owner, nxt_owner;
  logic [1:0] last, nxt_last;
  logic [3:0] gnt, nxt_gnt;
  logic       valid_q;
  logic [3:0] req, others, cand;
  logic [1:0] ptr;
  logic [2:0] win;
  logic       timeout_hit;
  logic       load_cnt;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_hold_range
    $error("arbiter_4: MAX_HOLD must be in 1..255");
  end

  assign req    = {req4, req3, req2, req1};
  assign others = req & ~(4'b0001 << owner);

  // {found, idx}: first candidate in order p+1, p+2, p+3, p. Scanning backwards
  // lets the earliest slot in rotation order overwrite later ones.
  function automatic logic [2:0] pick(input logic [1:0] p, input logic [3:0] c);
    logic [2:0] r;
    logic [1:0] i;
    r = '0;
    for (int k = 4; k >= 1; k--) begin
      i = p + 2'(k);
      if (c[i]) r = {1'b1, i};
    end
    return r;
  endfunction

  // One shared search: from `last` while idle, from the current owner (excluded) on handoff.
  assign ptr  = (state == IDLE) ? last : owner;
  assign cand = (state == IDLE) ? req  : others;
  assign win  = pick(ptr, cand);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD = 8'(MAX_HOLD);
  logic [7:0] cnt, nxt_cnt;

  assign timeout_hit = (cnt == HOLD) && (|others);

  always_comb begin
    nxt_cnt = cnt;
    if (nxt_state == IDLE)  nxt_cnt = 8'd0;
    else if (load_cnt)      nxt_cnt = 8'd1;
    else if (cnt != HOLD)   nxt_cnt = cnt + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 8'd0;
    else        cnt <= nxt_cnt;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    nxt_state = state;
    nxt_owner = owner;
    nxt_last  = last;
    nxt_gnt   = gnt;
    load_cnt  = 1'b0;
    case (state)
      IDLE: begin
        if (win[2]) begin
          nxt_state = GRANT;
          nxt_owner = win[1:0];
          nxt_gnt   = 4'b0001 << win[1:0];
          load_cnt  = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner] || timeout_hit) begin
          nxt_last = owner;
          if (win[2]) begin
            nxt_owner = win[1:0];
            nxt_gnt   = 4'b0001 << win[1:0];
            load_cnt  = 1'b1;
          end else begin
            nxt_state = IDLE;
            nxt_owner = 2'd0;
            nxt_gnt   = 4'b0000;
          end
        end
      end
      default: begin
        nxt_state = IDLE;
        nxt_owner = 2'd0;
        nxt_gnt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= 2'd0;
      last    <= 2'd3;
      gnt     <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      state   <= nxt_state;
      owner   <= nxt_owner;
      last    <= nxt_last;
      gnt     <= nxt_gnt;
      valid_q <= |nxt_gnt;
    end
  end

  assign {gnt4, gnt3, gnt2, gnt1} = gnt;
  assign valid                    = valid_q;
  assign {num1, num2}             = owner;

endmodule

// File: tb/tb_arbiter_4.sv
// Randomized and directed checks of arbiter_4 against a rotation-order reference model.
module tb_arbiter_4;
  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req1 = 1'b0, req2 = 1'b0, req3 = 1'b0, req4 = 1'b0;
  logic gnt1, gnt2, gnt3, gnt4, valid, num1, num2;

  int vecs = 0;
  int errs = 0;

  arbiter_4 #(.MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req1(req1), .req2(req2), .req3(req3), .req4(req4),
    .gnt1(gnt1), .gnt2(gnt2), .gnt3(gnt3), .gnt4(gnt4),
    .valid(valid), .num1(num1), .num2(num2)
  );

  always #5 clk = ~clk;

  wire [6:0] obs = {gnt4, gnt3, gnt2, gnt1, valid, num1, num2};

  // Reference model: owner index (-1 = nobody), last owner, hold count.
  int m_owner, m_last, m_cnt;

  function automatic int search(input int p, input logic [3:0] r);
    for (int k = 1; k <= 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_last = 3; m_cnt = 0;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    bit timeout;
    if (m_owner < 0) begin
      m_owner = search(m_last, r);
      m_cnt = (m_owner < 0) ? 0 : 1;
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      timeout = 0;
`ifdef ARB_TIMEOUT_EN
      timeout = (m_cnt == MAXH) && (oth != 0);
`endif
      if (!r[m_owner] || timeout) begin
        m_last  = m_owner;
        m_owner = search(m_last, oth);
        m_cnt   = (m_owner < 0) ? 0 : 1;
      end else if (m_cnt < MAXH) begin
        m_cnt++;
      end
    end
  endtask

  function automatic logic [6:0] expv();
    logic [3:0] g;
    logic [1:0] n;
    g = 4'b0000; n = 2'd0;
    if (m_owner >= 0) begin
      g[m_owner] = 1'b1;
      n = 2'(m_owner);
    end
    return {g, (m_owner >= 0), n};
  endfunction

  // Drive requests between edges, advance one edge, then settle at the falling edge.
  task automatic cyc(input logic [3:0] r);
    {req4, req3, req2, req1} = r;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    {req4, req3, req2, req1} = 4'b0000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vecs++;
    if (obs !== 7'b0000_000) begin
      errs++; $display("FAIL reset: got %b want %b", obs, 7'b0000_000);
    end
  endtask

  task automatic test_all_rise();
    do_reset();
    cyc(4'b1111);
    vecs++;
    if (obs !== 7'b0001_1_00 || obs !== expv()) begin
      errs++; $display("FAIL all_rise: got %b want %b", obs, 7'b0001_1_00);
    end
    cyc(4'b1110);
    vecs++;
    if (obs !== 7'b0010_1_01 || obs !== expv()) begin
      errs++; $display("FAIL handoff_no_gap: got %b want %b", obs, 7'b0010_1_01);
    end
  endtask

  task automatic test_no_preempt();
    logic [3:0] seq [6] = '{4'b0010, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0010};
    do_reset();
    foreach (seq[i]) begin
      cyc(seq[i]);
      vecs++;
      if (obs !== 7'b0010_1_01 || obs !== expv()) begin
        errs++; $display("FAIL no_preempt cyc %0d: got %b want %b", i, obs, 7'b0010_1_01);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [6] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b1000, 4'b1000};
    logic [6:0] want [6] = '{7'b0100_1_10, 7'b0100_1_10, 7'b0100_1_10,
                             7'b0100_1_10, 7'b1000_1_11, 7'b1000_1_11};
    do_reset();
    foreach (seq[i]) begin
      cyc(seq[i]);
      vecs++;
      if (obs !== want[i] || obs !== expv()) begin
        errs++; $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(4'b1000);
    vecs++;
    if (obs !== 7'b1000_1_11) begin
      errs++; $display("FAIL pre_reset_gnt4: got %b want %b", obs, 7'b1000_1_11);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vecs++;
    if (obs !== 7'b0000_000) begin
      errs++; $display("FAIL async_clear: got %b want %b", obs, 7'b0000_000);
    end
    {req4, req3, req2, req1} = 4'b0001;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0001);
    vecs++;
    if (obs !== 7'b0001_1_00 || obs !== expv()) begin
      errs++; $display("FAIL post_reset_gnt1: got %b want %b", obs, 7'b0001_1_00);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [6:0] want;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      cyc(4'b0011);
      want = ((c / MAXH) % 2 == 0) ? 7'b0001_1_00 : 7'b0010_1_01;
      vecs++;
      if (obs !== want || obs !== expv()) begin
        errs++; $display("FAIL timeout_alt cyc %0d: got %b want %b", c, obs, want);
      end
    end
    do_reset();
    for (int c = 0; c < 10; c++) begin
      cyc(4'b0100);
      vecs++;
      if (obs !== 7'b0100_1_10) begin
        errs++; $display("FAIL timeout_sole cyc %0d: got %b want %b", c, obs, 7'b0100_1_10);
      end
    end
  endtask
`else
  task automatic test_long_hold();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cyc(4'b0011);
      vecs++;
      if (obs !== 7'b0001_1_00) begin
        errs++; $display("FAIL long_hold cyc %0d: got %b want %b", c, obs, 7'b0001_1_00);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      // Flip each request with low probability so grants persist for a while.
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      cyc(r);
      vecs++;
      if (obs !== expv()) begin
        errs++; $display("FAIL random cyc %0d req %b: got %b want %b", c, r, obs, expv());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_all_rise();
    test_no_preempt();
    test_back_to_back();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_long_hold();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/arbiter_4.md
# arbiter_4

Round-robin arbiter sharing one resource among four requesters. Grants are one-hot and registered; the owner's index is also reported in the same 2-bit encoding our 4-input encoders produce, so the grant can drive downstream muxes directly. Grants are held until the owner releases its request, with optional forced revocation after a bounded hold time. Sits between the request lines of four client blocks and the shared datapath select.

## Interface
- MAX_HOLD, 8: maximum consecutive grant cycles before forced revocation (only with ARB_TIMEOUT_EN); legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req1, req2, req3, req4  input  1 each  level requests; req1 is requester index 0, req4 is index 3.
- gnt1, gnt2, gnt3, gnt4  output  1 each  one-hot grant, registered.
- valid  output  1  high when any grant is active.
- num1, num2  output  1 each  owner index {num1,num2}: req1=00, req2=01, req3=10, req4=11; 00 when valid low.

## Operation
- States: IDLE (no owner) and GRANT (owner held).
- Rotation pointer `last` holds the index of the most recent owner. Search order is last+1, last+2, last+3, last (mod 4). The first requester found with req high wins.
- IDLE: if any req is high at an edge, grant the winner and go to GRANT. Otherwise stay in IDLE.
- GRANT: at each edge, if the owner's req is still high, keep the grant (subject to timeout). If the owner's req is low, release the owner and set last = owner.
  - If any other req is high at that same edge, grant the next winner by rotation from the released owner, staying in GRANT (direct handoff).
  - Otherwise go to IDLE with all gnt low.
- The released owner can only regain the grant through rotation; it has the lowest priority on the next arbitration.
- Outputs are pure register outputs. valid = OR of gnt. num1/num2 are the encoded owner index.
- Reset values: state IDLE, last = 3 (so requester 1 wins the first arbitration), all gnt 0, valid 0, num1 0, num2 0, hold counter 0.

## Timing
- Request-to-grant latency is one cycle: a req sampled high at edge n gives gnt high after edge n.
- Release-to-next-grant gap is zero cycles. Old gnt falls and new gnt rises after the same edge.
- Simultaneous requests are resolved purely by rotation order. At most one gnt is ever high.
- A request dropped by a non-owner before it is granted is simply not considered. No request memory is kept.
- Asserting rst_n low mid-grant clears all outputs immediately, without waiting for a clock edge.
- After rst_n is deasserted, the first edge evaluates requests normally.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit hold counter loads 1 on every new grant and increments each edge while the same owner holds, saturating at MAX_HOLD.
  - At an edge where the count equals MAX_HOLD and another req is high, the owner is revoked even if its req is high. last = owner, and the next winner is granted after that edge.
  - If no other req is high, the grant is kept and the count stays at MAX_HOLD.
- ARB_TIMEOUT_EN undefined: no counter is built, MAX_HOLD is ignored, and the owner holds for as long as its req is high.

## Test plan
- Reset, then req1..req4 all rise together at cycle 1 -> gnt1=1, num=00 after the next edge; drop req1 -> gnt2=1, num=01 with no gap cycle.
- Owner req2 held, req1 pulsed high for 3 cycles then low -> gnt2 stays high; req1 is never granted.
- req3 only, released, then req3 and req4 together -> gnt3 first, after release gnt4 (num=11), valid stays high throughout.
- rst_n driven low while gnt4 is high, between clock edges -> gnt4, valid, num1, num2 all 0 immediately; after release with req1 high -> gnt1.
- ARB_TIMEOUT_EN, MAX_HOLD=4: req1 and req2 held high constantly -> gnt1 for 4 cycles, then gnt2 for 4 cycles, alternating.
- ARB_TIMEOUT_EN, MAX_HOLD=4, only req3 high for 10 cycles -> gnt3 held for all 10 cycles, no revocation.
